// File: rtl/pc_gen.sv
// Fetch-stage PC generator: increment, redirect, exception vectoring, stall-buffered redirect, EPC capture.
// Redirects show on address one cycle later. A redirect taken during hold waits in a buffer until hold releases.
module pc_gen #(
   parameter int          WIDTH      = 32,
   parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
   parameter logic [31:0] EXC_VEC    = 32'h8000_0180,
   parameter int          STEP       = 4,
   parameter int          ALIGN_BITS = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hold,
   input  logic             redirect,
   input  logic [WIDTH-1:0] target,
   input  logic             exception,
   output logic [WIDTH-1:0] address,
   output logic [WIDTH-1:0] pc_plus_step,
   output logic [WIDTH-1:0] epc,
   output logic             pending,
   output logic             misaligned
);

   localparam logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_VEC);
   localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VEC);
   localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
   // All-ones when ALIGN_BITS is 0, so no bits are masked and nothing is ever flagged.
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'((64'd1 << ALIGN_BITS) - 64'd1));

   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] epc_q, epc_d;
   logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic             pend_q, pend_d;
   logic             mis_q, mis_d;
   logic [WIDTH-1:0] tgt_aligned;
   logic             tgt_misaligned;

   assign tgt_aligned    = target & ALIGN_MASK;
   assign tgt_misaligned = (target & ~ALIGN_MASK) != '0;

   always_comb begin
      addr_d     = addr_q;
      epc_d      = epc_q;
      pend_tgt_d = pend_tgt_q;
      pend_d     = pend_q;
      mis_d      = redirect && tgt_misaligned && !exception;
      if (exception) begin
         addr_d = EXC_PC;
         epc_d  = addr_q;
         pend_d = 1'b0;
      end else if (hold) begin
         if (redirect) begin
            pend_tgt_d = tgt_aligned;
            pend_d     = 1'b1;
         end
      end else if (redirect) begin
         addr_d = tgt_aligned;
         pend_d = 1'b0;
      end else if (pend_q) begin
         addr_d = pend_tgt_q;
         pend_d = 1'b0;
      end else begin
         addr_d = addr_q + STEP_W;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q     <= RESET_PC;
         epc_q      <= '0;
         pend_tgt_q <= '0;
         pend_q     <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         addr_q     <= addr_d;
         epc_q      <= epc_d;
         pend_tgt_q <= pend_tgt_d;
         pend_q     <= pend_d;
         mis_q      <= mis_d;
      end
   end

   assign address      = addr_q;
   assign pc_plus_step = addr_q + STEP_W;
   assign epc          = epc_q;
   assign pending      = pend_q;
   assign misaligned   = mis_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the fetch stage. It is the successor to the plain hold/next PC register.
- Owns sequential increment, taken-branch/jump redirect, and exception vectoring.
- Buffers a redirect that arrives while fetch is stalled.
- Records the faulting PC (EPC) for the exception handler.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (low WIDTH bits used).
- EXC_VEC, 32'h8000_0180, PC value loaded on exception (low WIDTH bits used).
- STEP, 4, sequential increment in bytes.
- ALIGN_BITS, 2, number of low target bits forced to zero on redirect.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- hold  input  1  stall: PC keeps its value; redirects are buffered.
- redirect  input  1  load target this cycle (branch/jump resolved).
- target  input  WIDTH  redirect destination.
- exception  input  1  flush to EXC_VEC; overrides hold.
- address  output  WIDTH  current PC (registered).
- pc_plus_step  output  WIDTH  address+STEP (combinational, modulo 2^WIDTH).
- epc  output  WIDTH  PC captured at last exception (registered).
- pending  output  1  a buffered redirect is waiting for hold release (registered).
- misaligned  output  1  one-cycle flag: previous-cycle redirect had nonzero low ALIGN_BITS (registered).

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset state: address=RESET_VEC; epc=0; pending=0; internal pend_target=0; misaligned=0. rst overrides every other input in that cycle.
- Priority on each rising edge, highest first:
  - rst
  - exception
  - hold
  - redirect
  - pending buffer
  - sequential increment
- exception=1:
  - address<=EXC_VEC; epc<=address (PC before the update).
  - pending<=0. A redirect in the same cycle is discarded.
  - Takes effect even when hold=1.
- hold=1 and no exception:
  - address unchanged.
  - If redirect=1: pend_target<=aligned(target) and pending<=1. A later redirect during the same stall overwrites the earlier one (last wins).
  - If redirect=0: pending and pend_target unchanged.
- hold=0 and no exception:
  - If redirect=1: address<=aligned(target); pending<=0. A live redirect beats a buffered one.
  - Else if pending=1: address<=pend_target; pending<=0.
  - Else: address<=address+STEP. Overflow wraps modulo 2^WIDTH with no flag.
- aligned(x): x with bits [ALIGN_BITS-1:0] forced to 0. ALIGN_BITS=0 means no masking.
- misaligned: set on the next edge iff redirect=1 and target[ALIGN_BITS-1:0]!=0 in this cycle, regardless of hold. It is not set when exception or rst are active. Otherwise it clears. Always 0 when ALIGN_BITS=0.
- epc changes only on exception or rst.
- Latency:
  - Redirect with hold=0 is visible on address one cycle later.
  - Buffered redirect is visible one cycle after the first hold=0 cycle.
- Reset during a stall with pending=1: pending cleared, buffered target lost, address=RESET_VEC.
- pc_plus_step always tracks the current address, including during hold.

Test Plan:
- Reset then free-run (defaults): rst=1 for 2 cycles, then hold=0 -> address 0x0, 0x4, 0x8, 0xC on successive cycles; pc_plus_step=address+4; pending=0.
- Redirect: at address 0x10, redirect=1, target=0x0000_0400 -> next cycle address=0x400, then 0x404; misaligned stays 0.
- Buffered redirect: hold=1 at address 0x20; redirect pulses target=0x100 and then target=0x200 during the stall -> address stays 0x20, pending=1. Release hold -> address=0x200 one cycle later, pending=0, then 0x204.
- Exception under stall: address=0x40, hold=1, pending=1 (target 0x300), exception=1 -> address=0x8000_0180, epc=0x40, pending=0. Release hold -> 0x8000_0184.
- Misaligned and wrap: redirect target=0xFFFF_FFFE -> address=0xFFFF_FFFC and misaligned=1 for exactly one cycle. Next cycle address=0x0000_0000 (wrap); misaligned=0.
- Reset mid-stall: hold=1, pending=1, assert rst -> address=0x0, pending=0, epc=0. Deassert rst with hold=0 -> address 0x4 (no stale redirect applied).
